aes_key_schedule: RTL and testbench

- Sequences full AES-128 key expansion from one 128-bit cipher key.
- Holds all 11 round keys (rk0..rk10) in a local key store.
- Serves round keys to the cipher round datapath through a registered read port.
- Sits between the key input register and the AddRoundKey stage; the per-round key step is a sub-module.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_key_step.sv | 32 +++
 rtl/sbox_sync.sv | 16 +
 rtl/aes_key_schedule.sv | 87 ++++++++
 tb/tb_aes_key_schedule.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and the byte-level helpers (S-box, round
// constant) used by the key schedule datapath.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_word_t;

  localparam int NR_AES128 = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUB,
    ST_EXP,
    ST_DONE
  } ks_state_t;

  // Forward S-box, entry i at bits [2047-8*i -: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic aes_word_t rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 32'h0100_0000;
      4'd2:    return 32'h0200_0000;
      4'd3:    return 32'h0400_0000;
      4'd4:    return 32'h0800_0000;
      4'd5:    return 32'h1000_0000;
      4'd6:    return 32'h2000_0000;
      4'd7:    return 32'h4000_0000;
      4'd8:    return 32'h8000_0000;
      4'd9:    return 32'h1b00_0000;
      4'd10:   return 32'h3600_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key expansion step: RotWord/SubWord through synchronous S-boxes,
// then the XOR chain. next is valid one cycle after prev is presented and held.
module aes_key_step
  import aes_pkg::*;
(
  input  logic       clk,
  input  aes_state_t prev,
  input  logic [3:0] round,
  output aes_state_t next
);

  aes_word_t rot;
  aes_word_t sub;
  aes_word_t n0, n1, n2, n3;

  assign rot = {prev[23:0], prev[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    sbox_sync u_sbox (
      .clk  (clk),
      .data (rot[8*i +: 8]),
      .sub  (sub[8*i +: 8])
    );
  end

  assign n0   = prev[127:96] ^ sub ^ rcon(round);
  assign n1   = prev[95:64]  ^ n0;
  assign n2   = prev[63:32]  ^ n1;
  assign n3   = prev[31:0]   ^ n2;
  assign next = {n0, n1, n2, n3};

endmodule

// File: rtl/sbox_sync.sv
// One AES S-box with a registered output (one-cycle lookup latency).
module sbox_sync
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] data,
  output logic [7:0] sub
);

  // NOTE: pure datapath register with no reset; its value is only consumed
  // one cycle after the FSM has loaded a defined word into the lookup.
  always_ff @(posedge clk) begin
    sub <= sbox(data);
  end

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 key schedule: expands one cipher key into 11 round keys (two cycles
// per round) and serves them through a registered read port.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] key,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         keys_ready,
  output logic         busy,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);

  ks_state_t  state;
  logic [3:0] round_cnt;
  aes_state_t work;
  aes_state_t next_key;
  aes_state_t rk [0:NR];
  logic       accept;

  assign accept = key_valid && (state == ST_IDLE || state == ST_DONE);

  aes_key_step u_step (
    .clk   (clk),
    .prev  (work),
    .round (round_cnt),
    .next  (next_key)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      round_cnt  <= '0;
      work       <= '0;
      keys_ready <= 1'b0;
      busy       <= 1'b0;
      key_ready  <= 1'b1;
      rd_key     <= '0;
    end else begin
      rd_key <= (rd_round <= 4'(NR)) ? rk[rd_round] : '0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            work       <= key;
            round_cnt  <= 4'd1;
            keys_ready <= 1'b0;
            busy       <= 1'b1;
            key_ready  <= 1'b0;
            state      <= ST_SUB;
          end
        end
        ST_SUB: state <= ST_EXP;
        ST_EXP: begin
          work <= next_key;
          if (round_cnt == 4'(NR)) begin
            busy       <= 1'b0;
            keys_ready <= 1'b1;
            key_ready  <= 1'b1;
            state      <= ST_DONE;
          end else begin
            round_cnt <= round_cnt + 4'd1;
            state     <= ST_SUB;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the key store is deliberately left out of reset; its contents are
  // meaningless until keys_ready, and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (accept) begin
      rk[0] <= key;
    end else if (state == ST_EXP) begin
      rk[round_cnt] <= next_key;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a word-level FIPS-197 key
// expansion model whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] key;
  logic         key_valid;
  logic         key_ready;
  logic         keys_ready;
  logic         busy;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sbox_ref [0:255];
  logic [127:0] exp_rk   [0:10];

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_schedule dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key        (key),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .keys_ready (keys_ready),
    .busy       (busy),
    .rd_round   (rd_round),
    .rd_key     (rd_key)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box = affine map of the multiplicative inverse (a^254, with 0 -> 0).
  function automatic void build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h01;
      logic [7:0] b   = 8'(v);
      for (int k = 0; k < 254; k++) inv = gf_mul(inv, b);
      sbox_ref[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic void expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
        t ^= {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept k at edge 0, optionally pulse key_valid with other at edge 7, and
  // check handshake/status outputs after every edge through edge 20.
  task automatic run_key(input logic [127:0] k, input bit pulse7, input logic [127:0] other);
    key       = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check("accept_key_ready", 128'(key_ready), 128'(0));
    check("accept_keys_ready", 128'(keys_ready), 128'(0));
    for (int e = 1; e <= 20; e++) begin
      if (pulse7 && e == 7) begin
        key       = other;
        key_valid = 1'b1;
      end
      tick();
      key_valid = 1'b0;
      if (e < 20) begin
        check($sformatf("e%0d_key_ready", e), 128'(key_ready), 128'(0));
        check($sformatf("e%0d_busy", e), 128'(busy), 128'(1));
        check($sformatf("e%0d_keys_ready", e), 128'(keys_ready), 128'(0));
      end else begin
        check("e20_keys_ready", 128'(keys_ready), 128'(1));
        check("e20_busy", 128'(busy), 128'(0));
        check("e20_key_ready", 128'(key_ready), 128'(1));
      end
    end
  endtask

  task automatic check_store(input string pfx);
    for (int r = 0; r <= 10; r++) begin
      rd_round = 4'(r);
      tick();
      check($sformatf("%s_rk%0d", pfx, r), rd_key, exp_rk[r]);
    end
  endtask

  task automatic read_one(input int r, output logic [127:0] v);
    rd_round = 4'(r);
    tick();
    v = rd_key;
  endtask

  initial begin
    logic [127:0] v;
    logic [127:0] rkey;

    build_sbox();
    reset_n   = 1'b0;
    key       = '0;
    key_valid = 1'b0;
    rd_round  = '0;
    repeat (3) @(negedge clk);
    check("rst_keys_ready", 128'(keys_ready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_rd_key", rd_key, 128'(0));
    reset_n = 1'b1;
    tick();
    check("rst_key_ready", 128'(key_ready), 128'(1));

    // FIPS-197 vector
    expand(FIPS_KEY);
    run_key(FIPS_KEY, 1'b0, '0);
    read_one(1, v);  check("fips_rk1_const", v, FIPS_RK1);
    read_one(10, v); check("fips_rk10_const", v, FIPS_RK10);
    check_store("fips");

    // Out-of-range reads, then round 0
    for (int r = 11; r <= 15; r++) begin
      read_one(r, v);
      check($sformatf("oor_rd%0d", r), v, 128'(0));
    end
    read_one(0, v); check("rd0_loaded_key", v, FIPS_KEY);

    // All-zero key, then re-key from DONE with the FIPS key
    expand('0);
    run_key('0, 1'b0, '0);
    read_one(1, v);  check("zero_rk1_const", v, ZERO_RK1);
    read_one(10, v); check("zero_rk10_const", v, ZERO_RK10);
    expand(FIPS_KEY);
    run_key(FIPS_KEY, 1'b0, '0);
    read_one(10, v); check("rekey_fips_rk10", v, FIPS_RK10);

    // A key offered while busy is ignored
    rkey = {$urandom, $urandom, $urandom, $urandom};
    expand(rkey);
    run_key(rkey, 1'b1, ~rkey);
    check_store("ignore");

    // Asynchronous reset mid-expansion, then a full expansion
    rd_round  = 4'd0;
    key       = ~rkey;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (9) tick();
    #2 reset_n = 1'b0;
    #1;
    check("arst_keys_ready", 128'(keys_ready), 128'(0));
    check("arst_busy", 128'(busy), 128'(0));
    check("arst_rd_key", rd_key, 128'(0));
    check("arst_key_ready", 128'(key_ready), 128'(1));
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    rkey = {$urandom, $urandom, $urandom, $urandom};
    expand(rkey);
    run_key(rkey, 1'b0, '0);
    check_store("post_rst");

    // Randomized keys with random reads
    for (int n = 0; n < 4; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      expand(rkey);
      run_key(rkey, 1'b0, '0);
      check_store($sformatf("rand%0d", n));
      for (int j = 0; j < 6; j++) begin
        int r = int'($urandom_range(0, 15));
        read_one(r, v);
        check($sformatf("rand%0d_rd%0d", n, r), v, (r <= 10) ? exp_rk[r] : 128'(0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
